req_arbiter: RTL and testbench

REQ_ARBITER -- requirements
Module: req_arbiter

---
 rtl/req_arbiter.sv | 84 ++++++++
 tb/tb_req_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/req_arbiter.sv
// Round-robin arbiter over NUM_REQ sticky request lines, presenting a
// registered grant index A under a valid/ready handshake.
//
// state | meaning
// IDLE  | no grant presented, out_valid=0, A keeps last index
// HOLD  | grant presented on A, out_valid=1, waiting for out_ready
module req_arbiter #(
  parameter int NUM_REQ = 32,
  parameter int ADDR_W  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  A,
  output logic               out_valid,
  output logic [NUM_REQ-1:0] pend
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] p_q, p_nxt, sel_mask;
  logic [ADDR_W-1:0]  ptr, ptr_nxt, a_nxt, sel_idx;
  logic               sel_found, load;

  // Search starts one past the last grant and wraps, so ptr itself is
  // considered last; sel_found is therefore equivalent to p_q != 0.
  always_comb begin
    int j;
    sel_idx   = ptr;
    sel_found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      j = (int'(ptr) + i) % NUM_REQ;
      if (!sel_found && p_q[ADDR_W'(j)]) begin
        sel_found = 1'b1;
        sel_idx   = ADDR_W'(j);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (sel_found) begin
          load      = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (sel_found) load = 1'b1;
          else state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    a_nxt    = load ? sel_idx : A;
    ptr_nxt  = load ? sel_idx : ptr;
    sel_mask = load ? (NUM_REQ'(1) << sel_idx) : '0;
    // OR-ing req last lets a new request win over the clear of its own grant.
    p_nxt    = (p_q & ~sel_mask) | req;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      p_q   <= '0;
      A     <= '0;
      ptr   <= ADDR_W'(NUM_REQ - 1);
    end else begin
      state <= state_nxt;
      p_q   <= p_nxt;
      A     <= a_nxt;
      ptr   <= ptr_nxt;
    end
  end

  assign out_valid = (state == HOLD);
  assign pend      = p_q;

endmodule

// File: tb/tb_req_arbiter.sv
// Directed bench for req_arbiter: reset, single grant, round-robin sweep with
// a downstream decoder model, backpressure, wrap, set-over-clear, async reset.
module tb_req_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req;
  logic        out_ready;
  logic [4:0]  A;
  logic        out_valid;
  logic [31:0] pend;
  logic [31:0] dec;

  int checks = 0;
  int errors = 0;

  req_arbiter #(.NUM_REQ(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .req(req), .out_ready(out_ready),
    .A(A), .out_valid(out_valid), .pend(pend)
  );

  always #5 clk = ~clk;

  // One-cycle-latency 5-to-32 decoder fed by the grant.
  always_ff @(posedge clk) dec <= out_valid ? (32'd1 << A) : 32'd0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req = '0;
    out_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 32'hFFFF_FFFF;
    out_ready = 1'b1;
    tick();
    checks++;
    if (A !== 5'd0 || out_valid !== 1'b0 || pend !== 32'd0) begin
      errors++;
      $display("FAIL reset: A=%0d valid=%b pend=%h, want A=0 valid=0 pend=0", A, out_valid, pend);
    end
  endtask

  task automatic test_single();
    apply_reset();
    req = 32'h0000_0004;
    out_ready = 1'b1;
    tick();
    req = '0;
    checks++;
    if (out_valid !== 1'b0 || pend !== 32'h4) begin
      errors++;
      $display("FAIL single_latency: valid=%b pend=%h, want valid=0 pend=4", out_valid, pend);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || A !== 5'd2 || pend !== 32'd0) begin
      errors++;
      $display("FAIL single_grant: A=%0d valid=%b pend=%h, want A=2 valid=1 pend=0", A, out_valid, pend);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || pend !== 32'd0 || A !== 5'd2) begin
      errors++;
      $display("FAIL single_idle: A=%0d valid=%b pend=%h, want A=2 valid=0 pend=0", A, out_valid, pend);
    end
  endtask

  task automatic test_sweep();
    int exp_a;
    apply_reset();
    req = 32'hFFFF_FFFF;
    out_ready = 1'b1;
    tick();
    for (int n = 0; n < 33; n++) begin
      tick();
      exp_a = n % 32;
      checks++;
      if (out_valid !== 1'b1 || A !== 5'(exp_a)) begin
        errors++;
        $display("FAIL sweep[%0d]: A=%0d valid=%b, want A=%0d valid=1", n, A, out_valid, exp_a);
      end
      if (n > 0) begin
        checks++;
        if (dec !== (32'd1 << ((n - 1) % 32))) begin
          errors++;
          $display("FAIL decoder[%0d]: dec=%h, want %h", n, dec, 32'd1 << ((n - 1) % 32));
        end
      end
    end
    req = '0;
    repeat (34) tick();
  endtask

  task automatic test_backpressure();
    apply_reset();
    req = 32'h0000_0081;
    out_ready = 1'b0;
    tick();
    req = '0;
    for (int n = 0; n < 5; n++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || A !== 5'd0 || pend !== 32'h80) begin
        errors++;
        $display("FAIL bp_hold[%0d]: A=%0d valid=%b pend=%h, want A=0 valid=1 pend=80", n, A, out_valid, pend);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || A !== 5'd7) begin
      errors++;
      $display("FAIL bp_next: A=%0d valid=%b, want A=7 valid=1", A, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_idle: valid=%b, want 0", out_valid);
    end
  endtask

  // After granting 7, lines 3 and 9 pend: 9 comes first, then wrap to 3.
  task automatic test_rr_order();
    req = 32'h0000_0208;
    tick();
    req = '0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || A !== 5'd9) begin
      errors++;
      $display("FAIL rr_first: A=%0d valid=%b, want A=9 valid=1", A, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || A !== 5'd3) begin
      errors++;
      $display("FAIL rr_second: A=%0d valid=%b, want A=3 valid=1", A, out_valid);
    end
    tick();
  endtask

  task automatic test_wrap_single();
    apply_reset();
    req = 32'h8000_0000;
    out_ready = 1'b1;
    tick();
    req = '0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || A !== 5'd31) begin
      errors++;
      $display("FAIL wrap_first: A=%0d valid=%b, want A=31 valid=1", A, out_valid);
    end
    tick();
    req = 32'h8000_0000;
    tick();
    req = '0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || A !== 5'd31) begin
      errors++;
      $display("FAIL wrap_again: A=%0d valid=%b, want A=31 valid=1", A, out_valid);
    end
    tick();
  endtask

  task automatic test_set_over_clear();
    apply_reset();
    req = 32'h0000_0020;
    out_ready = 1'b1;
    tick();
    for (int n = 0; n < 4; n++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || A !== 5'd5 || pend !== 32'h20) begin
        errors++;
        $display("FAIL soc[%0d]: A=%0d valid=%b pend=%h, want A=5 valid=1 pend=20", n, A, out_valid, pend);
      end
    end
    req = '0;
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req = 32'h0000_F000;
    out_ready = 1'b0;
    tick();
    req = '0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || A !== 5'd12) begin
      errors++;
      $display("FAIL mid_pre: A=%0d valid=%b, want A=12 valid=1", A, out_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || pend !== 32'd0 || A !== 5'd0) begin
      errors++;
      $display("FAIL mid_async: A=%0d valid=%b pend=%h, want A=0 valid=0 pend=0", A, out_valid, pend);
    end
    tick();
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if (out_valid !== 1'b0 || pend !== 32'd0) begin
      errors++;
      $display("FAIL mid_after: valid=%b pend=%h, want valid=0 pend=0", out_valid, pend);
    end
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_sweep();
    test_backpressure();
    test_rr_order();
    test_wrap_single();
    test_set_over_clear();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
